// File: rtl/freq_scan_ctrl.sv
// rtl/freq_scan_ctrl.sv - round-robin scan scheduler driving one shared frequency meter
module freq_scan_ctrl #(
    parameter int N_CH        = 4,
    parameter int CH_W        = 2,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 400000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [N_CH-1:0] ch_mask,
    output logic [CH_W-1:0] ch_sel,
    output logic            meas_start,
    input  logic            meas_done,
    input  logic [31:0]     meas_value,
    output logic            result_valid,
    output logic [CH_W-1:0] result_ch,
    output logic [31:0]     result_freq,
    output logic [N_CH-1:0] timeout_flg,
    output logic            busy,
    input  logic [CH_W-1:0] rd_ch,
    output logic [31:0]     rd_freq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_START,
        S_WAIT,
        S_STORE
    } state_t;

    localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

    state_t          state_q, state_d;
    logic [CH_W-1:0] ch_sel_q, ch_sel_d;
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            to_hit_q, to_hit_d;
    logic            meas_start_q, meas_start_d;
    logic            result_valid_q, result_valid_d;
    logic [CH_W-1:0] result_ch_q, result_ch_d;
    logic [31:0]     result_freq_q, result_freq_d;
    logic [N_CH-1:0] timeout_flg_q, timeout_flg_d;
    logic            busy_q, busy_d;
    logic [31:0]     rd_freq_q, rd_freq_d;
    logic [31:0]     tbl_q [N_CH];
    logic [31:0]     tbl_d [N_CH];

    logic            pick_found;
    logic [CH_W-1:0] pick_ch;
    logic [CH_W-1:0] scan_idx;
    int              scan_sum;

    // first enabled channel at or after the round-robin pointer, wrapping
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = '0;
        scan_idx   = '0;
        scan_sum   = 0;
        for (int i = 0; i < N_CH; i++) begin
            scan_sum = int'(ptr_q) + i;
            if (scan_sum >= N_CH) begin
                scan_sum = scan_sum - N_CH;
            end
            scan_idx = CH_W'(scan_sum);
            if (!pick_found && ch_mask[scan_idx]) begin
                pick_found = 1'b1;
                pick_ch    = scan_idx;
            end
        end
    end

    // next-state, counters, result table and registered outputs
    always_comb begin
        state_d        = state_q;
        ch_sel_d       = ch_sel_q;
        ptr_d          = ptr_q;
        cnt_d          = cnt_q;
        to_hit_d       = to_hit_q;
        meas_start_d   = 1'b0;
        result_valid_d = 1'b0;
        result_ch_d    = result_ch_q;
        result_freq_d  = result_freq_q;
        timeout_flg_d  = timeout_flg_q;
        tbl_d          = tbl_q;
        rd_freq_d      = tbl_q[rd_ch];

        case (state_q)
            S_IDLE: begin
                if (run && (ch_mask != '0)) begin
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (!pick_found) begin
                    state_d = S_IDLE;
                end else begin
                    ch_sel_d = pick_ch;
                    cnt_d    = '0;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d        = '0;
                    meas_start_d = 1'b1;
                    state_d      = S_START;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_START: begin
                // counter tracks cycles since meas_start, so the timeout lands TIMEOUT_CYC after it
                cnt_d   = 32'd1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (meas_done) begin
                    result_freq_d  = meas_value;
                    to_hit_d       = 1'b0;
                    result_valid_d = 1'b1;
                    result_ch_d    = ch_sel_q;
                    state_d        = S_STORE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    result_freq_d  = '0;
                    to_hit_d       = 1'b1;
                    result_valid_d = 1'b1;
                    result_ch_d    = ch_sel_q;
                    state_d        = S_STORE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_STORE: begin
                tbl_d[ch_sel_q]         = result_freq_q;
                timeout_flg_d[ch_sel_q] = to_hit_q;
                if (ch_sel_q == CH_W'(N_CH - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = ch_sel_q + 1'b1;
                end
                state_d = run ? S_SELECT : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // single state register with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ch_sel_q       <= '0;
            ptr_q          <= '0;
            cnt_q          <= '0;
            to_hit_q       <= 1'b0;
            meas_start_q   <= 1'b0;
            result_valid_q <= 1'b0;
            result_ch_q    <= '0;
            result_freq_q  <= '0;
            timeout_flg_q  <= '0;
            busy_q         <= 1'b0;
            rd_freq_q      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            ch_sel_q       <= ch_sel_d;
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            to_hit_q       <= to_hit_d;
            meas_start_q   <= meas_start_d;
            result_valid_q <= result_valid_d;
            result_ch_q    <= result_ch_d;
            result_freq_q  <= result_freq_d;
            timeout_flg_q  <= timeout_flg_d;
            busy_q         <= busy_d;
            rd_freq_q      <= rd_freq_d;
            tbl_q          <= tbl_d;
        end
    end

    assign ch_sel       = ch_sel_q;
    assign meas_start   = meas_start_q;
    assign result_valid = result_valid_q;
    assign result_ch    = result_ch_q;
    assign result_freq  = result_freq_q;
    assign timeout_flg  = timeout_flg_q;
    assign busy         = busy_q;
    assign rd_freq      = rd_freq_q;

endmodule

// File: tb/tb_freq_scan_ctrl.sv
// tb/tb_freq_scan_ctrl.sv - randomized self-checking bench for freq_scan_ctrl
module tb_freq_scan_ctrl;

    localparam int N_CH    = 4;
    localparam int CH_W    = 2;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 1000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            run;
    logic [N_CH-1:0] ch_mask;
    logic [CH_W-1:0] ch_sel;
    logic            meas_start;
    logic            meas_done;
    logic [31:0]     meas_value;
    logic            result_valid;
    logic [CH_W-1:0] result_ch;
    logic [31:0]     result_freq;
    logic [N_CH-1:0] timeout_flg;
    logic            busy;
    logic [CH_W-1:0] rd_ch;
    logic [31:0]     rd_freq;

    freq_scan_ctrl #(
        .N_CH(N_CH), .CH_W(CH_W), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .ch_mask(ch_mask), .ch_sel(ch_sel),
        .meas_start(meas_start), .meas_done(meas_done), .meas_value(meas_value),
        .result_valid(result_valid), .result_ch(result_ch), .result_freq(result_freq),
        .timeout_flg(timeout_flg), .busy(busy), .rd_ch(rd_ch), .rd_freq(rd_freq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model of the scan table
    int          model_ptr;
    logic [31:0] model_tbl [N_CH];
    logic [N_CH-1:0] model_to;

    // meter behaviour controls
    int          resp_mode;      // 0 answer, 1 never answer, 2 answer on the timeout cycle
    bit          rand_mode;
    int          fixed_delay;    // 0 = random delay
    bit          fixed_vals;
    logic [31:0] val_override;
    int          gen;

    // expectation for the measurement in flight
    logic [31:0] exp_freq;
    int          exp_lat;
    logic        exp_to;

    // monitor bookkeeping
    int          cyc;
    int          n_starts;
    int          n_results;
    logic        inflight;
    logic [CH_W-1:0] inflight_ch;
    int          start_cyc;
    int          last_idle_cyc;
    int          last_rv_cyc;
    bit          flag_chk_pending;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int model_next(input logic [N_CH-1:0] m);
        for (int i = 0; i < N_CH; i++) begin
            if (m[(model_ptr + i) % N_CH]) return (model_ptr + i) % N_CH;
        end
        return 99;
    endfunction

    task automatic pulse_done(input logic [31:0] v);
        meas_value = v;
        meas_done  = 1'b1;
        @(posedge clk);
        #1 meas_done = 1'b0;
    endtask

    task automatic model_reset();
        model_ptr = 0;
        model_to  = '0;
        for (int i = 0; i < N_CH; i++) model_tbl[i] = '0;
    endtask

    // meter model: answers each meas_start according to the current controls
    initial begin
        int          d;
        int          mode;
        int          g;
        logic [31:0] v;
        forever begin
            @(negedge clk);
            if (rst_n && meas_start) begin
                mode = rand_mode ? (($urandom_range(0, 7) == 0) ? 1 : 0) : resp_mode;
                d    = (mode == 2) ? TIMEOUT - 1 :
                       ((fixed_delay != 0) ? fixed_delay : int'($urandom_range(3, 120)));
                v    = (val_override != 0) ? val_override :
                       (fixed_vals ? 32'(1000 * (int'(ch_sel) + 1)) : $urandom);
                exp_to   = (mode == 1);
                exp_freq = (mode == 1) ? 32'd0 : v;
                exp_lat  = (mode == 1) ? TIMEOUT : d + 1;
                if (mode != 1) begin
                    g = gen;
                    repeat (d) @(posedge clk);
                    #1;
                    if (g == gen) pulse_done(v);
                end
            end
        end
    end

    // monitor: checks every start and every result against the model
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (!busy) last_idle_cyc = cyc;
                if (flag_chk_pending) begin
                    chk("timeout_flg", 32'(timeout_flg), 32'(model_to));
                    flag_chk_pending = 0;
                end
                if (meas_start) begin
                    n_starts++;
                    chk("start_not_in_flight", 32'(inflight), 32'd0);
                    chk("ch_sel_pick", 32'(ch_sel), 32'(model_next(ch_mask)));
                    if (last_idle_cyc > last_rv_cyc)
                        chk("start_lat_from_idle", 32'(cyc - last_idle_cyc), 32'(SETTLE + 2));
                    else
                        chk("start_lat_from_store", 32'(cyc - last_rv_cyc), 32'(SETTLE + 2));
                    inflight    = 1'b1;
                    inflight_ch = ch_sel;
                    start_cyc   = cyc;
                end else if (inflight) begin
                    chk("ch_sel_hold", 32'(ch_sel), 32'(inflight_ch));
                end
                if (result_valid) begin
                    n_results++;
                    chk("rv_expected", 32'(inflight), 32'd1);
                    chk("result_ch", 32'(result_ch), 32'(inflight_ch));
                    chk("result_freq", result_freq, exp_freq);
                    chk("result_lat", 32'(cyc - start_cyc), 32'(exp_lat));
                    model_tbl[inflight_ch] = exp_freq;
                    model_to[inflight_ch]  = exp_to;
                    model_ptr   = (int'(inflight_ch) + 1) % N_CH;
                    inflight    = 1'b0;
                    last_rv_cyc = cyc;
                    flag_chk_pending = 1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_results(input int n);
        int target;
        int budget;
        target = n_results + n;
        budget = n * 1100 + 200;
        while (n_results < target && budget > 0) begin
            tick(1);
            budget--;
        end
        if (n_results < target) chk("wait_results_bound", 32'(n_results), 32'(target));
    endtask

    task automatic wait_start();
        int target;
        int budget;
        target = n_starts + 1;
        budget = 3000;
        while (n_starts < target && budget > 0) begin
            tick(1);
            budget--;
        end
        if (n_starts < target) chk("wait_start_bound", 32'(n_starts), 32'(target));
    endtask

    task automatic wait_idle();
        int budget;
        budget = 3000;
        while (busy && budget > 0) begin
            tick(1);
            budget--;
        end
        chk("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic read_check(input int ch);
        rd_ch = CH_W'(ch);
        tick(1);
        chk($sformatf("rd_freq[%0d]", ch), rd_freq, model_tbl[ch]);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ch_sel"}, 32'(ch_sel), 32'd0);
        chk({tag, "_meas_start"}, 32'(meas_start), 32'd0);
        chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        chk({tag, "_result_ch"}, 32'(result_ch), 32'd0);
        chk({tag, "_result_freq"}, result_freq, 32'd0);
        chk({tag, "_timeout_flg"}, 32'(timeout_flg), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rd_freq"}, rd_freq, 32'd0);
    endtask

    initial begin
        int s0;
        int r0;
        rst_n = 1'b0; run = 1'b0; ch_mask = '0; meas_done = 1'b0; meas_value = '0; rd_ch = '0;
        resp_mode = 0; rand_mode = 0; fixed_delay = 50; fixed_vals = 1; val_override = '0; gen = 0;
        exp_freq = '0; exp_lat = 0; exp_to = 0;
        cyc = 0; n_starts = 0; n_results = 0; inflight = 0; inflight_ch = '0; start_cyc = 0;
        last_idle_cyc = 0; last_rv_cyc = 0; flag_chk_pending = 0;
        model_reset();

        // reset values
        tick(3);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        tick(2);

        // full mask, fixed meter answers 1000*(ch+1)
        ch_mask = 4'b1111;
        run     = 1'b1;
        wait_results(5);
        run = 1'b0;
        wait_idle();
        chk("tbl2_is_3000", model_tbl[2], 32'd3000);
        read_check(2);
        for (int i = 0; i < N_CH; i++) read_check(i);

        // sparse mask, then narrow it while ch1 is being measured
        fixed_delay = 0;
        ch_mask = 4'b1010;
        run     = 1'b1;
        wait_results(4);
        for (int k = 0; k < 4; k++) begin
            wait_start();
            if (inflight_ch == 2'd1) break;
        end
        ch_mask = 4'b0100;
        wait_results(3);

        // dead meter on ch2, then recovery with 5000
        resp_mode = 1;
        wait_results(1);
        tick(1);
        chk("to_flag2_set", 32'(timeout_flg[2]), 32'd1);
        resp_mode = 0;
        val_override = 32'd5000;
        wait_results(1);
        tick(1);
        chk("to_flag2_cleared", 32'(timeout_flg[2]), 32'd0);

        // answer on the exact timeout cycle, then a spurious pulse in SETTLE
        resp_mode = 2;
        val_override = 32'd6000;
        wait_results(1);
        resp_mode = 0;
        val_override = '0;
        r0 = n_results;
        tick(1);
        pulse_done(32'd777);
        tick(3);
        chk("no_rv_from_settle_pulse", 32'(n_results), 32'(r0));
        chk("exact_to_stored", model_tbl[2], 32'd6000);
        wait_results(1);

        // drop run mid-measurement
        wait_start();
        tick(1);
        run = 1'b0;
        wait_results(1);
        s0 = n_starts;
        tick(30);
        chk("no_start_after_stop", 32'(n_starts), 32'(s0));
        chk("idle_after_stop", 32'(busy), 32'd0);
        r0 = n_results;
        pulse_done(32'd888);
        tick(5);
        chk("no_rv_from_idle_pulse", 32'(n_results), 32'(r0));
        ch_mask = '0;
        run     = 1'b1;
        tick(30);
        chk("mask0_stays_idle", 32'(busy), 32'd0);
        chk("mask0_no_start", 32'(n_starts), 32'(s0));
        run = 1'b0;

        // randomized scanning with random masks, delays, values and timeouts
        rand_mode  = 1;
        fixed_vals = 0;
        ch_mask    = 4'($urandom_range(1, 15));
        run        = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wait_start();
            if ($urandom_range(0, 2) == 0) ch_mask = 4'($urandom_range(1, 15));
            wait_results(1);
        end

        // asynchronous reset while waiting on the meter
        wait_start();
        tick(3);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        gen++;
        inflight = 1'b0;
        flag_chk_pending = 0;
        model_reset();
        run = 1'b0;
        rand_mode = 0; resp_mode = 0; fixed_delay = 20; fixed_vals = 1;
        tick(3);
        rst_n = 1'b1;
        tick(150);
        for (int i = 0; i < N_CH; i++) read_check(i);
        ch_mask = 4'b1111;
        run     = 1'b1;
        wait_results(2);
        run = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
